fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter PC_RESET, default 8'h00, PC value loaded on reset.
REQ-002 SHALL provide parameter HALT_ON_ZERO, default 1; 1 means a fetched word 16'h0000 halts fetching.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port imem_pc  output  8  address to the instruction ROM.
REQ-006 SHALL provide port imem_instr  input  16  ROM read data, combinational from imem_pc.
REQ-007 SHALL provide port out_valid  output  1  queue head holds a valid instruction.
REQ-008 SHALL provide port out_ready  input  1  decode accepts the head this cycle.
REQ-009 SHALL provide port out_instr  output  16  head instruction word.
REQ-010 SHALL provide port out_pc  output  8  address of the head instruction.
REQ-011 SHALL provide port redirect  input  1  branch/jump redirect request.
REQ-012 SHALL provide port redirect_pc  input  8  redirect target address.
REQ-013 SHALL provide port resume  input  1  leave HALT.
REQ-014 SHALL provide port halted  output  1  block is in HALT state.

Function
REQ-015 SHALL hold an 8-bit pc register and drive imem_pc = pc combinationally.
REQ-016 SHALL implement a 2-entry FIFO of {pc, instr}; out_* reflect the head; out_valid = (count != 0).
REQ-017 SHALL pop the head on any cycle with out_valid && out_ready.
REQ-018 SHALL use two states, FETCH and HALT; halted = (state == HALT).
REQ-019 In FETCH, SHALL push {pc, imem_instr} and increment pc when count < 2 or a pop occurs in the same cycle (push and pop together when full are legal; count unchanged).
REQ-020 SHALL hold pc and push nothing when full without a pop.
REQ-021 SHALL increment pc modulo 256 (8'hFF -> 8'h00), with no error indication.
REQ-022 Fetch latency: a word pushed in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1 if the queue was empty.
REQ-023 If HALT_ON_ZERO=1 and imem_instr == 16'h0000 on a would-push cycle, SHALL NOT push, SHALL hold pc at that address, and SHALL enter HALT.
REQ-024 In HALT, SHALL perform no pushes; existing entries SHALL still drain via the handshake.
REQ-025 In HALT, resume=1 SHALL set pc to pc+1 (skipping the zero word) and return to FETCH.
REQ-026 redirect=1 SHALL have highest priority in any state: flush the queue (count=0, any pop ignored), set pc to redirect_pc, push nothing that cycle, and enter FETCH.
REQ-027 After redirect in cycle N, out_valid SHALL be 0 in cycle N+1; the target instruction SHALL be on out_* in cycle N+2.
REQ-028 Simultaneous redirect and resume SHALL act as redirect only.
REQ-029 out_instr and out_pc SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-030 On reset=1 at a clock edge, SHALL set pc=PC_RESET, count=0, state=FETCH, out_valid=0, out_instr=16'h0000, out_pc=8'h00, halted=0, regardless of in-flight activity.
REQ-031 While reset=1, SHALL push nothing and SHALL ignore redirect and resume.

Verification
REQ-032 ROM 0..6 = 1012,1013,10B4,8232,6246,5003,0000 (hex); out_ready=1 -> out_pc 0..5 with those words on consecutive cycles from cycle 1; then halted=1, imem_pc=06, out_valid=0.
REQ-033 out_ready=0 for 5 cycles after reset -> count=2, imem_pc=02, out_instr=1012 stable; ready=1 -> 1012,1013,10B4 in order, no loss or duplicate.
REQ-034 Queue full, redirect=1 with redirect_pc=03 -> next cycle out_valid=0; following cycle out_pc=03, out_instr=8232.
REQ-035 In HALT at pc=06, redirect(redirect_pc=01) and resume together -> out_pc=01, out_instr=1013 two cycles later; pc 07 never fetched.
REQ-036 HALT_ON_ZERO=0, redirect to FF -> out_pc sequence FF, 00, 01.
REQ-037 reset=1 with queue full in FETCH -> next cycle out_valid=0, out_pc=00, out_instr=0000, imem_pc=PC_RESET, halted=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: pc register, 2-entry {pc, instr} queue toward decode,
// and a FETCH/HALT controller with redirect flush and halt-on-zero-word.
module fetch_unit #(
  parameter logic [7:0] PC_RESET     = 8'h00,
  parameter bit         HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  imem_pc,
  input  logic [15:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [7:0]  out_pc,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  input  logic        resume,
  output logic        halted
);

  // state | meaning
  // FETCH | pushing {pc, instr} into the queue whenever a slot is free
  // HALT  | zero word seen; no pushes, queue still drains, waits for resume
  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  state_t      state, state_n;
  logic [7:0]  pc, pc_n;
  logic [1:0]  count;
  logic [23:0] entry0, entry1;
  logic        pop, push, flush, can_push, zero_word;
  logic [23:0] new_entry;

  assign imem_pc   = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = entry0[23:16];
  assign out_instr = entry0[15:0];
  assign halted    = (state == HALT);

  assign pop       = out_valid && out_ready;
  assign can_push  = (count < 2'd2) || pop;
  assign zero_word = HALT_ON_ZERO && (imem_instr == 16'h0000);
  assign new_entry = {pc, imem_instr};

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect) begin
      // Redirect outranks everything, including a same-cycle resume or pop.
      flush   = 1'b1;
      pc_n    = redirect_pc;
      state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (can_push) begin
            if (zero_word) begin
              state_n = HALT;
            end else begin
              push = 1'b1;
              pc_n = pc + 8'd1;
            end
          end
        end
        HALT: begin
          if (resume) begin
            pc_n    = pc + 8'd1;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= PC_RESET;
      count  <= 2'd0;
      entry0 <= 24'h0;
      entry1 <= 24'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (flush) begin
        count <= 2'd0;
      end else if (push && pop) begin
        if (count == 2'd2) begin
          entry0 <= entry1;
          entry1 <= new_entry;
        end else begin
          entry0 <= new_entry;
        end
      end else if (pop) begin
        entry0 <= entry1;
        count  <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) entry0 <= new_entry;
        else               entry1 <= new_entry;
        count <= count + 2'd1;
      end
    end
  end

endmodule
